// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer. It steps through fetch, decode, execute, memory and writeback.
// It issues one-cycle phase strobes, counts retired instructions and traps on a memory timeout or an illegal opcode.
module multicycle_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_ack,
  input  logic                  dmem_ack,
  input  logic                  Load,
  input  logic                  Store,
  input  logic                  Branch,
  input  logic                  next_sel,
  input  logic                  branch_result,
  input  logic                  reg_write_req,
  input  logic                  illegal_instr,
  output logic                  imem_req,
  output logic                  ir_load,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic                  rf_we,
  output logic                  pc_we,
  output logic                  pc_sel,
  output logic                  busy,
  output logic                  trap,
  output logic [DATA_WIDTH-1:0] instret,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd7
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [CW-1:0]           wait_reg, wait_next;
  logic [DATA_WIDTH-1:0]   instret_reg, instret_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      wait_reg    <= '0;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      instret_reg <= instret_next;
    end
  end

  // The wait counter is zero everywhere except during an unacknowledged memory wait.
  // This makes it clear automatically on entry to FETCH and MEM.
  always_comb begin
    state_next   = state_reg;
    wait_next    = '0;
    instret_next = instret_reg;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    busy         = 1'b0;
    trap         = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_TRAP;
        end else begin
          wait_next = wait_reg + CW'(1);
        end
      end
      S_DECODE: begin
        busy       = 1'b1;
        state_next = illegal_instr ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        busy       = 1'b1;
        state_next = (Load | Store) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        busy     = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = Store & ~Load;
        if (dmem_ack) begin
          state_next = S_WRITEBACK;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = S_TRAP;
        end else begin
          wait_next = wait_reg + CW'(1);
        end
      end
      S_WRITEBACK: begin
        busy         = 1'b1;
        pc_we        = 1'b1;
        rf_we        = reg_write_req & ~Store & ~Branch;
        pc_sel       = next_sel | (Branch & branch_result);
        instret_next = instret_reg + DATA_WIDTH'(1);
        state_next   = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_next = S_TRAP;
    endcase
  end

  assign instret = instret_reg;
  assign state_o = state_reg;

endmodule
